// File: rtl/shared_dff_reg_arbiter.sv
// Round-robin write arbiter owning a single shared W-bit register (q/qbar).
// Optional last-writer output is enabled by defining ARB_LAST_ID_EN.
module shared_dff_reg_arbiter #(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic [W-1:0]         q,
    output logic [W-1:0]         qbar
`ifdef ARB_LAST_ID_EN
   ,output logic [$clog2(N)-1:0] last_id
`endif
);
    localparam int PW = $clog2(N);
    localparam logic [3:0] HOLD_LAST = 4'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t         state_q;
    logic [PW-1:0]  ptr_q, sel_q;
    logic [PW-1:0]  sel_d, ptr_d;
    logic [N-1:0]   gnt_q;
    logic           busy_q;
    logic [W-1:0]   data_q;
    logic [3:0]     hold_cnt_q;
`ifdef ARB_LAST_ID_EN
    logic [PW-1:0]  last_id_q;
`endif

    // Scan downward from ptr+N-1 to ptr so the lowest offset from ptr wins.
    always_comb begin
        sel_d = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) sel_d = PW'(idx);
        end
    end

    assign ptr_d = (sel_q == PW'(N - 1)) ? '0 : sel_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            hold_cnt_q <= '0;
`ifdef ARB_LAST_ID_EN
            last_id_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel_q   <= sel_d;
                        gnt_q   <= {{(N-1){1'b0}}, 1'b1} << sel_d;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_q <= '0;
                    if (req[sel_q]) begin
                        data_q     <= wdata[int'(sel_q)*W +: W];
                        ptr_q      <= ptr_d;
                        hold_cnt_q <= '0;
`ifdef ARB_LAST_ID_EN
                        last_id_q  <= sel_q;
`endif
                        if (HOLD_CYCLES > 0) begin
                            state_q <= HOLD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        // Requester withdrew: no write, pointer stays put.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_q <= '0;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign q    = data_q;
    assign qbar = ~data_q;
`ifdef ARB_LAST_ID_EN
    assign last_id = last_id_q;
`endif

endmodule

// File: tb/tb_shared_dff_reg_arbiter.sv
// Directed bench: instance a uses HOLD_CYCLES=1, instance b uses HOLD_CYCLES=0.
module tb_shared_dff_reg_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_a, req_b;
    logic [31:0] wdata_a, wdata_b;
    logic [3:0]  gnt_a, gnt_b;
    logic        busy_a, busy_b;
    logic [7:0]  q_a, qbar_a, q_b, qbar_b;
`ifdef ARB_LAST_ID_EN
    logic [1:0]  lid_a, lid_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shared_dff_reg_arbiter #(.N(4), .W(8), .HOLD_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .wdata(wdata_a),
        .gnt(gnt_a), .busy(busy_a), .q(q_a), .qbar(qbar_a)
`ifdef ARB_LAST_ID_EN
       ,.last_id(lid_a)
`endif
    );

    shared_dff_reg_arbiter #(.N(4), .W(8), .HOLD_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .wdata(wdata_b),
        .gnt(gnt_b), .busy(busy_b), .q(q_b), .qbar(qbar_b)
`ifdef ARB_LAST_ID_EN
       ,.last_id(lid_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs and samples both happen 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fd [5];
        logic [3:0] fg [5];
        fd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        fg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1;
        req_a = 4'($urandom); wdata_a = $urandom;
        req_b = 4'($urandom); wdata_b = $urandom;
        step();
        step();
        chk("rst_q", q_a, 8'h00);
        chk("rst_qbar", qbar_a, 8'hFF);
        chk("rst_gnt", gnt_a, 4'b0000);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_gnt_b", gnt_b, 4'b0000);
`ifdef ARB_LAST_ID_EN
        chk("rst_lid", lid_a, 2'd0);
`endif
        rst = 1'b0; req_a = 4'b0000; req_b = 4'b0000; wdata_b = '0;

        // Fairness: all four held, ptr starts at 0.
        req_a = 4'b1111; wdata_a = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("fair_gnt%0d", i), gnt_a, fg[i]);
            chk($sformatf("fair_busy%0d", i), busy_a, 1'b1);
            step();
            chk($sformatf("fair_q%0d", i), q_a, fd[i]);
            chk($sformatf("fair_gclr%0d", i), gnt_a, 4'b0000);
            if (i == 4) req_a = 4'b0000;
            step();
            chk($sformatf("fair_idle%0d", i), busy_a, 1'b0);
        end

        // Single write from requester 2 (ptr now 1).
        req_a = 4'b0100; wdata_a = 32'h00A50000;
        step();
        chk("sw_gnt", gnt_a, 4'b0100);
        chk("sw_busy0", busy_a, 1'b1);
        chk("sw_q_pre", q_a, 8'h11);
        step();
        chk("sw_q", q_a, 8'hA5);
        chk("sw_qbar", qbar_a, 8'h5A);
        chk("sw_gclr", gnt_a, 4'b0000);
        chk("sw_busy1", busy_a, 1'b1);
        req_a = 4'b0000;
        step();
        chk("sw_busy2", busy_a, 1'b0);
        chk("sw_q_hold", q_a, 8'hA5);

        // Abort: requester 1 drops req during GRANT.
        req_a = 4'b0010; wdata_a = 32'h00007700;
        step();
        chk("ab_gnt", gnt_a, 4'b0010);
        req_a = 4'b0000;
        step();
        chk("ab_q", q_a, 8'hA5);
        chk("ab_busy", busy_a, 1'b0);
        chk("ab_gclr", gnt_a, 4'b0000);
        req_a = 4'b0010;
        step();
        chk("ab_regnt", gnt_a, 4'b0010);
        step();
        chk("ab_q2", q_a, 8'h77);
        req_a = 4'b0000;
        step();

        // Abort must leave ptr alone: ptr=2, so {1,2} resolves to 2.
        req_a = 4'b0010;
        step();
        req_a = 4'b0000;
        step();
        req_a = 4'b0110; wdata_a = 32'h00C37700;
        step();
        chk("ab_ptr_gnt", gnt_a, 4'b0100);
        step();
        chk("ab_ptr_q", q_a, 8'hC3);
        req_a = 4'b0000;
        step();

        // Reset at the GRANT exit edge: no commit, ptr back to 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a = 4'b0001; wdata_a = 32'h0000003C;
        step();
        chk("mr_gnt", gnt_a, 4'b0001);
        rst = 1'b1;
        step();
        chk("mr_q", q_a, 8'h00);
        chk("mr_gnt0", gnt_a, 4'b0000);
        chk("mr_busy", busy_a, 1'b0);
        rst = 1'b0;
        req_a = 4'b0011; wdata_a = 32'h00005D3C;
        step();
        chk("mr_next", gnt_a, 4'b0001);
        step();
        chk("mr_q2", q_a, 8'h3C);
        req_a = 4'b0000;
        step();

        // HOLD_CYCLES=0: requesters 1 and 3 alternate every 2 cycles.
        req_b = 4'b1010; wdata_b = 32'hD300B100;
        step();
        chk("b_gnt0", gnt_b, 4'b0010);
        step();
        chk("b_q0", q_b, 8'hB1);
        chk("b_qbar0", qbar_b, 8'h4E);
        chk("b_busy0", busy_b, 1'b0);
`ifdef ARB_LAST_ID_EN
        chk("b_lid0", lid_b, 2'd1);
`endif
        step();
        chk("b_gnt1", gnt_b, 4'b1000);
        step();
        chk("b_q1", q_b, 8'hD3);
`ifdef ARB_LAST_ID_EN
        chk("b_lid1", lid_b, 2'd3);
`endif
        step();
        chk("b_gnt2", gnt_b, 4'b0010);
        step();
        chk("b_q2", q_b, 8'hB1);
`ifdef ARB_LAST_ID_EN
        chk("b_lid2", lid_b, 2'd1);
`endif
        req_b = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/shared_dff_reg_arbiter.md
# shared_dff_reg_arbiter

Round-robin write arbiter for a single shared W-bit D-flip-flop register, with q/qbar outputs.
- N requesters compete for write access.
- The block grants one requester at a time with a registered one-hot grant.
- It commits that requester's data into the register, then enforces a configurable hold-off before the next arbitration.
- It sits between multiple producer blocks and the shared storage flops. It is the only writer of those flops.

## Interface
Parameters:
- N, 4: number of requesters, 2..8.
- W, 8: register/data width.
- HOLD_CYCLES, 1: idle cycles after each committed write, 0..15.

Ports:
- clk  in  1  rising-edge clock, only clock domain.
- rst  in  1  reset, synchronous and active-high.
- req  in  N  per-requester write request, level.
- wdata  in  N*W  requester i data at bits [i*W +: W].
- gnt  out  N  registered one-hot grant; all-zero when no grant.
- busy  out  1  high whenever state is not IDLE.
- q  out  W  shared register contents.
- qbar  out  W  bitwise inverse of q, always.

## Operation
State machine: IDLE, GRANT, HOLD.
- IDLE: if req is nonzero at a rising edge, pick the winner and go to GRANT. gnt becomes one-hot for the winner. sel is the registered winner index.
  - Winner is the first set req bit scanning ptr, ptr+1, … modulo N.
- GRANT, lasts exactly one cycle:
  - If req[sel] is still high, q <= wdata[sel] and ptr <= (sel+1) mod N.
    - With HOLD_CYCLES > 0, go to HOLD. With HOLD_CYCLES == 0, go to IDLE.
  - If req[sel] is low (abort), q is unchanged, ptr is unchanged, go to IDLE directly.
  - gnt clears to 0 at the GRANT exit edge in both cases.
- HOLD: a 4-bit counter runs for HOLD_CYCLES cycles, then goes to IDLE. req is ignored during HOLD.
- Requester rules:
  - Keep req and wdata stable from assertion through the cycle in which its gnt bit is high.
  - Drop req in the cycle after seeing gnt, or keep it high to re-queue.
- Reset values: state IDLE, ptr 0, gnt 0, busy 0, q all zeros, qbar all ones, hold counter 0.

## Timing
- Sampling edge e0 (IDLE, req≠0): after e0, gnt is valid and busy=1.
- Edge e1: q/qbar update and gnt=0.
- Write latency is 2 edges from the sampling edge.
- Throughput is one write per 2+HOLD_CYCLES cycles under continuous requests.
- Abort costs 2 cycles: IDLE→GRANT→IDLE, with busy high for 1 cycle.
- Simultaneous requests are resolved by ptr only. There are no priorities beyond round-robin.
- A requester asserting req during GRANT or HOLD is considered at the first IDLE edge.
- Reset mid-operation: rst high at an edge overrides everything.
  - An in-flight GRANT does not commit.
  - All outputs and ptr return to reset values at that edge.
- qbar is always ~q. It is derived from the same flops, never independently registered.

## Configuration
- ARB_LAST_ID_EN defined: adds output last_id, width $clog2(N).
  - last_id is loaded with sel on each committed write.
  - It is unchanged on abort and reset to 0.
- ARB_LAST_ID_EN undefined: no last_id port and no associated flops. All other behaviour is identical.

## Test plan
(N=4, W=8, HOLD_CYCLES=1 unless stated.)
- Reset: rst=1 for 2 cycles with random req/wdata → q=8'h00, qbar=8'hFF, gnt=4'b0000, busy=0.
- Single write: req=4'b0100, wdata[2]=8'hA5 → gnt=4'b0100 for 1 cycle after e0; q=8'hA5, qbar=8'h5A after e1; busy high 2 cycles.
- Fairness: req=4'b1111 held continuously with distinct wdata 8'h11/22/33/44 → grant order 0,1,2,3,0, with a write every 3 cycles.
- Abort: req=4'b0010 with wdata 8'h77; drop req[1] during GRANT → q unchanged; busy high 1 cycle; the next req=4'b0010 is granted to requester 1 again.
- Reset mid-op: rst=1 at the GRANT exit edge with wdata[0]=8'h3C → q stays 8'h00, gnt=0, state IDLE, next winner is requester 0.
- HOLD_CYCLES=0 back-to-back: req=4'b1010 held → writes from 1 then 3 alternate every 2 cycles; with ARB_LAST_ID_EN, last_id follows 1,3,1.
